// File: rtl/fbu_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters; grant is combinational, read data returns 1 cycle later.
// Losers stall with req held. Optional burst locking is enabled by defining FBU_ARB_LOCK_EN.
module fbu_ram_arbiter #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int MAX_BURST     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_a,
  input  logic                     we_a,
  input  logic [ADDRESS_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0]    wdata_a,
  input  logic                     lock_a,
  output logic                     gnt_a,
  output logic                     rvalid_a,
  output logic [DATA_WIDTH-1:0]    rdata_a,
  input  logic                     req_b,
  input  logic                     we_b,
  input  logic [ADDRESS_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0]    wdata_b,
  input  logic                     lock_b,
  output logic                     gnt_b,
  output logic                     rvalid_b,
  output logic [DATA_WIDTH-1:0]    rdata_b,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;   // 0: A wins a contended cycle, 1: B wins
  logic   rv_a_q, rv_b_q;

`ifdef FBU_ARB_LOCK_EN
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  logic [3:0] cnt_q, cnt_d;
`else
  logic unused_lock;
  assign unused_lock = lock_a ^ lock_b ^ (MAX_BURST > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      rv_a_q  <= 1'b0;
      rv_b_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      rv_a_q  <= gnt_a & ~we_a;
      rv_b_q  <= gnt_b & ~we_b;
    end
  end

`ifdef FBU_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    state_d = state_q;
    prio_d  = prio_q;
`ifdef FBU_ARB_LOCK_EN
    cnt_d   = cnt_q;
`endif

    if (!rst) begin
      case (state_q)
        OWN_A:   gnt_a = req_a;
        OWN_B:   gnt_b = req_b;
        default: begin
          gnt_a = req_a && (!req_b || !prio_q);
          gnt_b = req_b && !gnt_a;
        end
      endcase
    end

    if (gnt_a)      prio_d = 1'b1;
    else if (gnt_b) prio_d = 1'b0;

`ifdef FBU_ARB_LOCK_EN
    // A burst of length 1 never needs to hold ownership.
    case (state_q)
      IDLE: begin
        if (gnt_a && lock_a && BURST_MAX > 4'd1) begin
          state_d = OWN_A;
          cnt_d   = 4'd1;
        end else if (gnt_b && lock_b && BURST_MAX > 4'd1) begin
          state_d = OWN_B;
          cnt_d   = 4'd1;
        end
      end
      OWN_A: begin
        cnt_d = gnt_a ? cnt_q + 4'd1 : cnt_q;
        if (!gnt_a || !lock_a || (cnt_q + 4'd1) == BURST_MAX) state_d = IDLE;
      end
      OWN_B: begin
        cnt_d = gnt_b ? cnt_q + 4'd1 : cnt_q;
        if (!gnt_b || !lock_b || (cnt_q + 4'd1) == BURST_MAX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`else
    state_d = IDLE;
`endif
  end

  assign ram_we    = (gnt_a & we_a) | (gnt_b & we_b);
  assign ram_addr  = gnt_a ? addr_a  : (gnt_b ? addr_b  : '0);
  assign ram_wdata = gnt_a ? wdata_a : (gnt_b ? wdata_b : '0);

  // Returns launched just before a reset are dropped in the reset cycle itself.
  assign rvalid_a = rv_a_q & ~rst;
  assign rvalid_b = rv_b_q & ~rst;
  assign rdata_a  = rvalid_a ? ram_rdata : '0;
  assign rdata_b  = rvalid_b ? ram_rdata : '0;

endmodule

// File: tb/tb_fbu_ram_arbiter.sv
// Directed bench for fbu_ram_arbiter with a write-first synchronous RAM model behind it.
module tb_fbu_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, we_a, lock_a, req_b, we_b, lock_b;
  logic [5:0] addr_a, addr_b, ram_addr;
  logic [9:0] wdata_a, wdata_b, ram_wdata, ram_rdata;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we;
  logic [9:0] rdata_a, rdata_b;
  logic [9:0] mem [64];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fbu_ram_arbiter #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .lock_a(lock_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .lock_b(lock_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 10'(i);
      mem[1] <= 10'h011;
      mem[2] <= 10'h022;
      mem[5] <= 10'h155;
      ram_rdata <= '0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      ram_rdata     <= ram_wdata;
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply inputs just after the falling edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic ra, input logic wa, input logic [5:0] aa,
                       input logic [9:0] da, input logic la, input logic rb, input logic wb,
                       input logic [5:0] ab, input logic [9:0] db, input logic lb);
    @(negedge clk);
    rst = r;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da; lock_a = la;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db; lock_b = lb;
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_gnt_a"}, 32'(gnt_a), 0);
    chk({tag, "_gnt_b"}, 32'(gnt_b), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
    chk({tag, "_rvalid_a"}, 32'(rvalid_a), 0);
    chk({tag, "_rvalid_b"}, 32'(rvalid_b), 0);
  endtask

  initial begin
    rst = 1'b1;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0; lock_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0; lock_b = 0;

    // Reset state, including a write request that must be suppressed.
    drive(1, 0, 0, 6'd0, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    idle_outputs("reset");
    chk("reset_rdata_a", 32'(rdata_a), 0);
    chk("reset_rdata_b", 32'(rdata_b), 0);
    drive(1, 1, 1, 6'd7, 10'h2AA, 0, 0, 0, 6'd0, 10'h0, 0);
    chk("reset_we_blocked", 32'(ram_we), 0);
    chk("reset_gnt_blocked", 32'(gnt_a), 0);

    // Single read from A.
    drive(0, 1, 0, 6'd5, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    chk("rd_a_gnt_a", 32'(gnt_a), 1);
    chk("rd_a_gnt_b", 32'(gnt_b), 0);
    chk("rd_a_addr", 32'(ram_addr), 5);
    chk("rd_a_we", 32'(ram_we), 0);
    chk("rd_a_rvalid_early", 32'(rvalid_a), 0);
    drive(0, 0, 0, 6'd0, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    chk("rd_a_rvalid", 32'(rvalid_a), 1);
    chk("rd_a_rdata", 32'(rdata_a), 32'h155);
    chk("rd_a_rvalid_b", 32'(rvalid_b), 0);
    chk("rd_a_rdata_b", 32'(rdata_b), 0);
    chk("rd_a_gnt_after", 32'(gnt_a), 0);

    // Single read from B returns the pointer to A.
    drive(0, 0, 0, 6'd0, 10'h0, 0, 1, 0, 6'd2, 10'h0, 0);
    chk("rd_b_gnt_b", 32'(gnt_b), 1);
    chk("rd_b_addr", 32'(ram_addr), 2);

    // Contended reads alternate A,B,A,B with returns one cycle behind.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 6'd1, 10'h0, 0, 1, 0, 6'd2, 10'h0, 0);
      chk($sformatf("alt%0d_gnt_a", k), 32'(gnt_a), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_gnt_b", k), 32'(gnt_b), (k % 2 == 0) ? 0 : 1);
      chk($sformatf("alt%0d_rvalid_a", k), 32'(rvalid_a), (k % 2 == 0) ? 0 : 1);
      chk($sformatf("alt%0d_rvalid_b", k), 32'(rvalid_b), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_rdata", k), 32'(rvalid_a ? rdata_a : rdata_b),
          (k % 2 == 0) ? 32'h022 : 32'h011);
    end
    drive(0, 0, 0, 6'd0, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    chk("alt_tail_rvalid_b", 32'(rvalid_b), 1);
    chk("alt_tail_rdata_b", 32'(rdata_b), 32'h022);

    // B writes 63, A reads it back.
    drive(0, 0, 0, 6'd0, 10'h0, 0, 1, 1, 6'd63, 10'h3FF, 0);
    chk("wr_b_gnt_b", 32'(gnt_b), 1);
    chk("wr_b_we", 32'(ram_we), 1);
    chk("wr_b_addr", 32'(ram_addr), 63);
    chk("wr_b_wdata", 32'(ram_wdata), 32'h3FF);
    drive(0, 1, 0, 6'd63, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    chk("raw_gnt_a", 32'(gnt_a), 1);
    chk("raw_rvalid_b", 32'(rvalid_b), 0);
    drive(0, 0, 0, 6'd0, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    chk("raw_rvalid_a", 32'(rvalid_a), 1);
    chk("raw_rdata_a", 32'(rdata_a), 32'h3FF);
    chk("raw_rvalid_b2", 32'(rvalid_b), 0);

    // Idle cycles leave the pointer alone: A was granted last, so B wins next.
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 6'd0, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
      idle_outputs($sformatf("idle%0d", k));
    end
    drive(0, 1, 0, 6'd3, 10'h0, 0, 1, 0, 6'd4, 10'h0, 0);
    chk("post_idle_gnt_b", 32'(gnt_b), 1);
    chk("post_idle_gnt_a", 32'(gnt_a), 0);

    // Reset right after an A read grant discards the return and reloads priority to A.
    drive(0, 1, 0, 6'd5, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    chk("pre_rst_gnt_a", 32'(gnt_a), 1);
    drive(1, 0, 0, 6'd0, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    chk("rst_rvalid_a", 32'(rvalid_a), 0);
    chk("rst_rdata_a", 32'(rdata_a), 0);
    drive(0, 1, 0, 6'd1, 10'h0, 0, 1, 0, 6'd2, 10'h0, 0);
    chk("post_rst_rvalid_a", 32'(rvalid_a), 0);
    chk("post_rst_gnt_a", 32'(gnt_a), 1);
    chk("post_rst_gnt_b", 32'(gnt_b), 0);

    // Locked contention from A, starting from a fresh reset.
    drive(1, 0, 0, 6'd0, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 6'd1, 10'h0, 1, 1, 0, 6'd2, 10'h0, 0);
`ifdef FBU_ARB_LOCK_EN
      chk($sformatf("lock%0d_gnt_a", k), 32'(gnt_a), (k == 4) ? 0 : 1);
      chk($sformatf("lock%0d_gnt_b", k), 32'(gnt_b), (k == 4) ? 1 : 0);
`else
      chk($sformatf("lock%0d_gnt_a", k), 32'(gnt_a), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("lock%0d_gnt_b", k), 32'(gnt_b), (k % 2 == 0) ? 0 : 1);
`endif
    end
    drive(0, 0, 0, 6'd0, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    drive(0, 0, 0, 6'd0, 10'h0, 0, 0, 0, 6'd0, 10'h0, 0);
    idle_outputs("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
